// File: rtl/tx_text_arbiter.sv
// tx_text_arbiter: round-robin share of the MinOS text-transmit channel among NUM_REQ producers.
// Latency: grant at the IDLE edge, req_ack next cycle, tx_start one cycle after that.
// Backpressure: one frame at a time; losers stay pending until MinOS finishes or times out.
// Option: define TX_ARB_PRIO0_EN to give requester 0 absolute priority over a round-robin of 1..NUM_REQ-1.
module tx_text_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TEXT_BYTES     = 32,
   parameter int START_WAIT     = 16,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*TEXT_BYTES*8-1:0]  req_bytes,
   input  logic [NUM_REQ*8-1:0]             req_size,
   output logic [NUM_REQ-1:0]               req_ack,
   output logic [TEXT_BYTES*8-1:0]          tx_text_bytes,
   output logic [7:0]                       tx_text_size,
   output logic                             tx_start,
   input  logic                             tx_busy,
   output logic [7:0]                       grant_index,
   output logic                             arb_busy,
   output logic                             err_pulse
);

   localparam int IW      = $clog2(NUM_REQ);
   localparam int BW      = TEXT_BYTES * 8;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > START_WAIT) ? TIMEOUT_CYCLES : START_WAIT;
   localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef TX_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CAPTURE   = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_q;
   logic [IW-1:0]   grant_q;
   logic [BW-1:0]   bytes_q;
   logic [7:0]      size_q;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW:0]     scan_sum;
   logic [BW-1:0]   cap_bytes;
   logic [7:0]      cap_size;
   logic            start_to;
   logic            done_to;

   // Winner search: optional requester-0 override, else first pending index at or after rr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      if (PRIO0 && req_valid[0]) begin
         win_found = 1'b1;
         win_idx   = '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ)) begin
               scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            end
            // Under priority mode index 0 is handled above and excluded from the rotation.
            if (!win_found && req_valid[scan_sum[IW-1:0]] &&
                !(PRIO0 && scan_sum[IW-1:0] == '0)) begin
               win_found = 1'b1;
               win_idx   = scan_sum[IW-1:0];
            end
         end
      end
   end

   // Select the winner's buffer and clamp its byte count to the text port width.
   always_comb begin
      cap_bytes = '0;
      cap_size  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IW'(i)) begin
            cap_bytes = req_bytes[i*BW +: BW];
            cap_size  = req_size[i*8 +: 8];
         end
      end
      if (cap_size > 8'(TEXT_BYTES)) begin
         cap_size = 8'(TEXT_BYTES);
      end
   end

   assign start_to = (cnt_q == CW'(START_WAIT - 1));
   assign done_to  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (win_found) state_d = S_CAPTURE;
         S_CAPTURE:   state_d = (size_q == 8'd0) ? S_IDLE : S_START;
         S_START:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (tx_busy)       state_d = S_WAIT_DONE;
            else if (start_to) state_d = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (!tx_busy)      state_d = S_IDLE;
            else if (done_to)  state_d = S_IDLE;
         end
         default:     state_d = S_IDLE;
      endcase
   end

   // Wait counter: restarts on every state change, counts while waiting, saturates at its maximum.
   always_comb begin
      cnt_d = '0;
      if ((state_d == state_q) &&
          (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE)) begin
         cnt_d = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Datapath: capture buffer, grant and rotation pointer only on the IDLE grant edge.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rr_q    <= '0;
         grant_q <= '0;
         bytes_q <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (state_q == S_IDLE && win_found) begin
            grant_q <= win_idx;
            bytes_q <= cap_bytes;
            size_q  <= cap_size;
            // A priority grant to requester 0 leaves the rotation untouched.
            if (!(PRIO0 && win_idx == '0)) begin
               rr_q <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      tx_start  = (state_q == S_START);
      arb_busy  = (state_q != S_IDLE);
      err_pulse = ((state_q == S_WAIT_BUSY) && !tx_busy && start_to) ||
                  ((state_q == S_WAIT_DONE) &&  tx_busy && done_to);
      req_ack   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ack[i] = (state_q == S_CAPTURE) && (grant_q == IW'(i));
      end
   end

   assign tx_text_bytes = bytes_q;
   assign tx_text_size  = size_q;
   assign grant_index   = {{(8-IW){1'b0}}, grant_q};

endmodule
